dit_fft_8: RTL and testbench
============================

# dit_fft_8

Eight-point radix-2 decimation-in-time FFT with a registered, stallable pipeline. It accepts one complex 8-sample frame per clock and produces the 8 complex frequency bins three enabled clocks later. All samples are 16-bit sign-magnitude fixed point. It is the transform core between the sample-capture front end and the spectral post-processing logic.

## Interface
- No parameters. Widths are fixed by the package constants.
- clk  in  1  sole clock; rising-edge active.
- RST_N  in  1  reset; asynchronous, active-high (the name is kept for codebase compatibility).
- write  in  1  load the in* buses into the input register on this edge.
- start  in  1  pipeline enable; stages S1..S3 advance only on edges where start=1.
- in0_r..in7_r  in  16 each  real part of time sample n; format is sign[15], integer[14:8], fraction[7:0].
- in0_i..in7_i  in  16 each  imaginary part of sample n; same format.
- out0_r..out7_r  out  16 each  real part of bin k; same format.
- out0_i..out7_i  out  16 each  imaginary part of bin k; same format.
- ready  out  1  the out* buses hold a valid transformed frame.

## Operation
- Computes X[k] = Σ x[n]·W8^(nk) with W8 = e^(−j2π/8). There is no 1/N scaling.
- Sign-magnitude conversion:
  - Inputs are converted to 20-bit two's complement internally.
  - −0 (0x8000) is treated as 0.
  - Results are converted back to sign-magnitude. Zero is always emitted as 0x0000.
- S0 (input register):
  - Captures bit-reversed inputs when write=1, and sets v0=write.
  - A frame captured while start=0 is overwritten by the next write, or its v0 is cleared if write=0.
- S1: two-point butterflies (W8^0).
- S2: butterflies with W8^0 and W8^2 = −j. These are swap/negate operations only.
- S3: butterflies with W8^0, W8^1, W8^2 and W8^3.
- Twiddle multiply for W8^1 and W8^3:
  - Uses the constant C = 181 (0.70711 in Q0.8).
  - Each product is (a·C + 128) >>> 8, computed in two's complement.
- A valid bit accompanies each stage: v1, v2 and v3. ready = v3.
- When start=0, all of S1..S3 and their valid bits hold. The outputs and ready stay stable.

## Timing
- Latency: a frame written at edge k, with start=1 at edges k+1, k+2 and k+3, appears on out* with ready=1 after edge k+3.
- Throughput: one frame per clock while write=1 and start=1.
- Reset clears all stage data and valid bits immediately. All out* go to 0x0000 and ready goes to 0.
  - Reset mid-stream discards every in-flight frame.
  - The first frame written after reset release follows normal latency.
- Simultaneous write=1 and start=1: S0 loads a new frame while its previous content moves into S1 on the same edge.

## Configuration
- DIT_FFT_8_SATURATE_EN:
  - Defined: any output whose magnitude exceeds 0x7FFF is clamped to magnitude 0x7FFF, keeping its sign.
  - Undefined: the magnitude wraps modulo 2^15. This gives smaller logic.

## Structure
- Package dit_fft_8_pkg holds:
  - DW=16 and IW=20.
  - TW_C=181.
  - The typedef for a complex sample.
  - The sign-magnitude to two's complement conversion functions, in both directions.
- Sub-module dit_fft_8_bfly: one complex radix-2 butterfly with a selectable twiddle (W8^0..W8^3). It is instantiated 12 times, 4 per stage.

## Test plan
- Reset: assert RST_N mid-operation -> all out* = 0x0000 and ready=0 at once, without waiting for a clock edge.
- Ramp frame, real 0x0000..0x0700 with imaginary parts 0, then start -> ready after 3 enabled edges with:
  - out0_r=0x1C00.
  - out2 = 0x8400 + j0x0400.
  - out4 = 0x8400 + j0x0000.
  - out6 = 0x8400 + j0x8400.
  - out1_i ≈ 0x09A8 and out7_i ≈ 0x89A8, each ±2 LSB.
- Back-to-back streaming, write=start=1 for three consecutive frames 0x0400,0500,0600,0700,0800,0900,0400,0500 / 0x0100..0x0800 / 0x0100,0000,0500,0800,0600,0700,0300,0100 -> on three consecutive cycles out0_r = 0x3000, then 0x2400, then 0x1F00, with ready held at 1.
- Stall: drop start for 2 cycles mid-stream -> outputs and ready are frozen, and no frame is lost or duplicated.
- Overflow: all in*_r = 0x7F00 -> out0_r = 0x7FFF with DIT_FFT_8_SATURATE_EN defined, or the wrapped value without it. All other bins = 0x0000.
- Negative zero: every input 0x8000 -> every output 0x0000.

Source files
------------

// File: rtl/dit_fft_8_pkg.sv
// Shared widths, twiddle constant, complex sample type and number-format helpers
// for the 8-point DIT FFT. Build option: DIT_FFT_8_SATURATE_EN (clamp output magnitude).
package dit_fft_8_pkg;

  localparam int unsigned DW   = 16;  // external sign-magnitude width
  localparam int unsigned IW   = 20;  // internal two's complement width
  localparam int          TW_C = 181; // cos(pi/4) in Q0.8

  typedef struct packed {
    logic signed [IW-1:0] re;
    logic signed [IW-1:0] im;
  } cplx_t;

  // Sign-magnitude to two's complement; -0 naturally maps to 0.
  function automatic logic signed [IW-1:0] sm_to_tc(input logic [DW-1:0] v);
    logic signed [IW-1:0] mag;
    mag = IW'(v[DW-2:0]);
    return v[DW-1] ? -mag : mag;
  endfunction

  // Two's complement to sign-magnitude; a zero magnitude never carries a sign.
  function automatic logic [DW-1:0] tc_to_sm(input logic signed [IW-1:0] v);
    logic [IW-1:0]   mag;
    logic [DW-2:0]   m15;
    mag = v[IW-1] ? IW'(-v) : IW'(v);
`ifdef DIT_FFT_8_SATURATE_EN
    m15 = (mag > IW'(32'h7FFF)) ? 15'h7FFF : mag[DW-2:0];
`else
    m15 = mag[DW-2:0];
`endif
    return {v[IW-1] && (m15 != '0), m15};
  endfunction

  // Rounded multiply by C: (a*C + 128) >>> 8.
  function automatic logic signed [IW-1:0] tw_mul(input logic signed [IW:0] a);
    logic signed [31:0] p;
    p = 32'(a) * 32'(TW_C) + 32'sd128;
    return p[IW+7:8];
  endfunction

  function automatic logic [2:0] bit_rev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

endpackage

// File: rtl/dit_fft_8_bfly.sv
// One complex radix-2 butterfly: y0 = a + W*b, y1 = a - W*b, W = W8^Twiddle.
module dit_fft_8_bfly
  import dit_fft_8_pkg::*;
#(
  parameter int unsigned Twiddle = 0
) (
  input  logic signed [IW-1:0] a_r,
  input  logic signed [IW-1:0] a_i,
  input  logic signed [IW-1:0] b_r,
  input  logic signed [IW-1:0] b_i,
  output logic signed [IW-1:0] y0_r,
  output logic signed [IW-1:0] y0_i,
  output logic signed [IW-1:0] y1_r,
  output logic signed [IW-1:0] y1_i
);

  logic signed [IW:0]   br_x;
  logic signed [IW:0]   bi_x;
  logic signed [IW-1:0] t_r;
  logic signed [IW-1:0] t_i;

  assign br_x = (IW+1)'(b_r);
  assign bi_x = (IW+1)'(b_i);

  // Twiddle product W*b; W1 = C(1-j), W2 = -j, W3 = C(-1-j).
  always_comb begin
    t_r = b_r;
    t_i = b_i;
    case (Twiddle)
      1: begin
        t_r = tw_mul(br_x + bi_x);
        t_i = tw_mul(bi_x - br_x);
      end
      2: begin
        t_r = b_i;
        t_i = -b_r;
      end
      3: begin
        t_r = tw_mul(bi_x - br_x);
        t_i = tw_mul(-br_x - bi_x);
      end
      default: begin
        t_r = b_r;
        t_i = b_i;
      end
    endcase
  end

  assign y0_r = a_r + t_r;
  assign y0_i = a_i + t_i;
  assign y1_r = a_r - t_r;
  assign y1_i = a_i - t_i;

endmodule

// File: rtl/dit_fft_8.sv
// Eight-point radix-2 DIT FFT, stallable 4-register pipeline (S0 input, S1..S3 butterflies).
// Build option: DIT_FFT_8_SATURATE_EN clamps output magnitudes instead of wrapping.
module dit_fft_8
  import dit_fft_8_pkg::*;
(
  input  logic          clk,
  input  logic          RST_N,
  input  logic          write,
  input  logic          start,
  input  logic [DW-1:0] in0_r,
  input  logic [DW-1:0] in1_r,
  input  logic [DW-1:0] in2_r,
  input  logic [DW-1:0] in3_r,
  input  logic [DW-1:0] in4_r,
  input  logic [DW-1:0] in5_r,
  input  logic [DW-1:0] in6_r,
  input  logic [DW-1:0] in7_r,
  input  logic [DW-1:0] in0_i,
  input  logic [DW-1:0] in1_i,
  input  logic [DW-1:0] in2_i,
  input  logic [DW-1:0] in3_i,
  input  logic [DW-1:0] in4_i,
  input  logic [DW-1:0] in5_i,
  input  logic [DW-1:0] in6_i,
  input  logic [DW-1:0] in7_i,
  output logic [DW-1:0] out0_r,
  output logic [DW-1:0] out1_r,
  output logic [DW-1:0] out2_r,
  output logic [DW-1:0] out3_r,
  output logic [DW-1:0] out4_r,
  output logic [DW-1:0] out5_r,
  output logic [DW-1:0] out6_r,
  output logic [DW-1:0] out7_r,
  output logic [DW-1:0] out0_i,
  output logic [DW-1:0] out1_i,
  output logic [DW-1:0] out2_i,
  output logic [DW-1:0] out3_i,
  output logic [DW-1:0] out4_i,
  output logic [DW-1:0] out5_i,
  output logic [DW-1:0] out6_i,
  output logic [DW-1:0] out7_i,
  output logic          ready
);

  logic [DW-1:0] in_r [8];
  logic [DW-1:0] in_i [8];

  assign in_r = '{in0_r, in1_r, in2_r, in3_r, in4_r, in5_r, in6_r, in7_r};
  assign in_i = '{in0_i, in1_i, in2_i, in3_i, in4_i, in5_i, in6_i, in7_i};

  cplx_t s0_q [8];
  cplx_t s1_q [8];
  cplx_t s2_q [8];
  cplx_t s3_q [8];
  logic  v0_q, v1_q, v2_q, v3_q;

  logic signed [IW-1:0] s1_r_d [8];
  logic signed [IW-1:0] s1_i_d [8];
  logic signed [IW-1:0] s2_r_d [8];
  logic signed [IW-1:0] s2_i_d [8];
  logic signed [IW-1:0] s3_r_d [8];
  logic signed [IW-1:0] s3_i_d [8];

  // S1: adjacent pairs, W8^0.
  for (genvar g = 0; g < 4; g++) begin : g_s1
    dit_fft_8_bfly #(.Twiddle(0)) u_bfly (
      .a_r  (s0_q[2*g].re),
      .a_i  (s0_q[2*g].im),
      .b_r  (s0_q[2*g+1].re),
      .b_i  (s0_q[2*g+1].im),
      .y0_r (s1_r_d[2*g]),
      .y0_i (s1_i_d[2*g]),
      .y1_r (s1_r_d[2*g+1]),
      .y1_i (s1_i_d[2*g+1])
    );
  end

  // S2: span-2 pairs, W8^0 then W8^2 within each group of four.
  for (genvar g = 0; g < 4; g++) begin : g_s2
    localparam int          Lo = (g / 2) * 4 + (g % 2);
    localparam int unsigned Tw = 2 * (g % 2);
    dit_fft_8_bfly #(.Twiddle(Tw)) u_bfly (
      .a_r  (s1_q[Lo].re),
      .a_i  (s1_q[Lo].im),
      .b_r  (s1_q[Lo+2].re),
      .b_i  (s1_q[Lo+2].im),
      .y0_r (s2_r_d[Lo]),
      .y0_i (s2_i_d[Lo]),
      .y1_r (s2_r_d[Lo+2]),
      .y1_i (s2_i_d[Lo+2])
    );
  end

  // S3: span-4 pairs, twiddle W8^g; results land in natural bin order.
  for (genvar g = 0; g < 4; g++) begin : g_s3
    dit_fft_8_bfly #(.Twiddle(g)) u_bfly (
      .a_r  (s2_q[g].re),
      .a_i  (s2_q[g].im),
      .b_r  (s2_q[g+4].re),
      .b_i  (s2_q[g+4].im),
      .y0_r (s3_r_d[g]),
      .y0_i (s3_i_d[g]),
      .y1_r (s3_r_d[g+4]),
      .y1_i (s3_i_d[g+4])
    );
  end

  // S0: capture a bit-reversed, two's complement frame; v0 tracks write every edge.
  always_ff @(posedge clk or posedge RST_N) begin
    if (RST_N) begin
      v0_q <= 1'b0;
      for (int i = 0; i < 8; i++) s0_q[i] <= '0;
    end else begin
      v0_q <= write;
      if (write) begin
        for (int i = 0; i < 8; i++) begin
          s0_q[i] <= '{re: sm_to_tc(in_r[bit_rev3(3'(i))]),
                       im: sm_to_tc(in_i[bit_rev3(3'(i))])};
        end
      end
    end
  end

  // S1..S3: advance together only when start is high, otherwise hold.
  always_ff @(posedge clk or posedge RST_N) begin
    if (RST_N) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        s1_q[i] <= '0;
        s2_q[i] <= '0;
        s3_q[i] <= '0;
      end
    end else if (start) begin
      v1_q <= v0_q;
      v2_q <= v1_q;
      v3_q <= v2_q;
      for (int i = 0; i < 8; i++) begin
        s1_q[i] <= '{re: s1_r_d[i], im: s1_i_d[i]};
        s2_q[i] <= '{re: s2_r_d[i], im: s2_i_d[i]};
        s3_q[i] <= '{re: s3_r_d[i], im: s3_i_d[i]};
      end
    end
  end

  assign ready  = v3_q;
  assign out0_r = tc_to_sm(s3_q[0].re);
  assign out1_r = tc_to_sm(s3_q[1].re);
  assign out2_r = tc_to_sm(s3_q[2].re);
  assign out3_r = tc_to_sm(s3_q[3].re);
  assign out4_r = tc_to_sm(s3_q[4].re);
  assign out5_r = tc_to_sm(s3_q[5].re);
  assign out6_r = tc_to_sm(s3_q[6].re);
  assign out7_r = tc_to_sm(s3_q[7].re);
  assign out0_i = tc_to_sm(s3_q[0].im);
  assign out1_i = tc_to_sm(s3_q[1].im);
  assign out2_i = tc_to_sm(s3_q[2].im);
  assign out3_i = tc_to_sm(s3_q[3].im);
  assign out4_i = tc_to_sm(s3_q[4].im);
  assign out5_i = tc_to_sm(s3_q[5].im);
  assign out6_i = tc_to_sm(s3_q[6].im);
  assign out7_i = tc_to_sm(s3_q[7].im);

endmodule

// File: tb/tb_dit_fft_8.sv
// Self-checking bench for dit_fft_8: frame-level FFT model plus hand-computed literals.
module tb_dit_fft_8;

  logic        clk = 1'b0;
  logic        RST_N = 1'b1;
  logic        write = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_r [8];
  logic [15:0] in_i [8];
  logic [15:0] out_r [8];
  logic [15:0] out_i [8];
  logic        ready;

  int total = 0;
  int bad = 0;
  int cur_id = -1;
  int m0 = -1, m1 = -1, m2 = -1, m3 = -1;
  logic chk_en = 1'b0;

  logic [15:0] fr_r [8][8];
  logic [15:0] fr_i [8][8];
  logic [15:0] ex_r [8][8];
  logic [15:0] ex_i [8][8];

  always #5 clk = ~clk;

  dit_fft_8 dut (
    .clk(clk), .RST_N(RST_N), .write(write), .start(start),
    .in0_r(in_r[0]), .in1_r(in_r[1]), .in2_r(in_r[2]), .in3_r(in_r[3]),
    .in4_r(in_r[4]), .in5_r(in_r[5]), .in6_r(in_r[6]), .in7_r(in_r[7]),
    .in0_i(in_i[0]), .in1_i(in_i[1]), .in2_i(in_i[2]), .in3_i(in_i[3]),
    .in4_i(in_i[4]), .in5_i(in_i[5]), .in6_i(in_i[6]), .in7_i(in_i[7]),
    .out0_r(out_r[0]), .out1_r(out_r[1]), .out2_r(out_r[2]), .out3_r(out_r[3]),
    .out4_r(out_r[4]), .out5_r(out_r[5]), .out6_r(out_r[6]), .out7_r(out_r[7]),
    .out0_i(out_i[0]), .out1_i(out_i[1]), .out2_i(out_i[2]), .out3_i(out_i[3]),
    .out4_i(out_i[4]), .out5_i(out_i[5]), .out6_i(out_i[6]), .out7_i(out_i[7]),
    .ready(ready)
  );

  function automatic int sm2int(input logic [15:0] v);
    int m;
    m = int'(v[14:0]);
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] int2sm(input int v);
    int m;
    logic [15:0] r;
    m = (v < 0) ? -v : v;
`ifdef DIT_FFT_8_SATURATE_EN
    if (m > 32767) m = 32767;
`else
    m = m % 32768;
`endif
    r = 16'(m);
    r[15] = (v < 0) && (m != 0);
    return r;
  endfunction

  function automatic int rnd(input int x);
    return (x * 181 + 128) >>> 8;
  endfunction

  // Textbook in-place radix-2 DIT transform of frame id into ex_r/ex_i.
  task automatic model_fft(input int id);
    int ar [8];
    int ai [8];
    int rv, lo, hi, k, tr, ti, ur, ui;
    for (int n = 0; n < 8; n++) begin
      rv = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      ar[rv] = sm2int(fr_r[id][n]);
      ai[rv] = sm2int(fr_i[id][n]);
    end
    for (int len = 2; len <= 8; len = len * 2) begin
      for (int s = 0; s < 8; s = s + len) begin
        for (int j = 0; j < len / 2; j++) begin
          lo = s + j;
          hi = lo + len / 2;
          k  = j * (8 / len);
          case (k)
            0: begin tr = ar[hi]; ti = ai[hi]; end
            1: begin tr = rnd(ar[hi] + ai[hi]); ti = rnd(ai[hi] - ar[hi]); end
            2: begin tr = ai[hi]; ti = -ar[hi]; end
            default: begin tr = rnd(ai[hi] - ar[hi]); ti = rnd(-ar[hi] - ai[hi]); end
          endcase
          ur = ar[lo];
          ui = ai[lo];
          ar[lo] = ur + tr;
          ai[lo] = ui + ti;
          ar[hi] = ur - tr;
          ai[hi] = ui - ti;
        end
      end
    end
    for (int b = 0; b < 8; b++) begin
      ex_r[id][b] = int2sm(ar[b]);
      ex_i[id][b] = int2sm(ai[b]);
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_near(input string name, input logic [15:0] act,
                            input logic [15:0] exp, input int tol);
    int d;
    total++;
    d = sm2int(act) - sm2int(exp);
    if ($isunknown(act) || act[15] !== exp[15] || d > tol || d < -tol) begin
      bad++;
      $display("FAIL %s: got %h expected %h +-%0d at %0t", name, act, exp, tol, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, 16'(ready), 16'h0000);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_out%0d_r", name, k), out_r[k], 16'h0000);
      check($sformatf("%s_out%0d_i", name, k), out_i[k], 16'h0000);
    end
  endtask

  // Frame-identity view of the pipeline: which frame should sit in each stage.
  always @(posedge clk or posedge RST_N) begin
    if (RST_N) begin
      m0 <= -1; m1 <= -1; m2 <= -1; m3 <= -1;
    end else begin
      if (start) begin
        m1 <= m0; m2 <= m1; m3 <= m2;
      end
      m0 <= write ? cur_id : -1;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en && !RST_N) begin
      check("ready", 16'(ready), 16'(m3 >= 0));
      if (m3 >= 0) begin
        for (int k = 0; k < 8; k++) begin
          check($sformatf("f%0d_bin%0d_r", m3, k), out_r[k], ex_r[m3][k]);
          check($sformatf("f%0d_bin%0d_i", m3, k), out_i[k], ex_i[m3][k]);
        end
      end
    end
  end

  task automatic step(input logic w, input logic s, input int id);
    write  = w;
    start  = s;
    cur_id = w ? id : -1;
    if (w) begin
      for (int n = 0; n < 8; n++) begin
        in_r[n] = fr_r[id][n];
        in_i[n] = fr_i[id][n];
      end
    end
    @(posedge clk);
    #2;
  endtask

  logic [15:0] tmp [8];
  logic [15:0] ovf_exp;

  initial begin
    for (int n = 0; n < 8; n++) begin
      in_r[n] = 16'h0000;
      in_i[n] = 16'h0000;
    end
    // 0: ramp, 1..3: streaming frames, 4..5: mixed-sign complex, 6: overflow, 7: -0.
    for (int n = 0; n < 8; n++) begin
      fr_r[0][n] = 16'(n * 256);
      fr_i[0][n] = 16'h0000;
      fr_r[2][n] = 16'((n + 1) * 256);
      fr_i[2][n] = 16'h0000;
      fr_r[4][n] = 16'(n * 17 + 5) | ((n % 2 == 1) ? 16'h8000 : 16'h0000);
      fr_i[4][n] = 16'(n * 33 + 300) | ((n % 3 == 0) ? 16'h8000 : 16'h0000);
      fr_r[6][n] = 16'h7F00;
      fr_i[6][n] = 16'h0000;
      fr_r[7][n] = 16'h8000;
      fr_i[7][n] = 16'h8000;
      fr_i[1][n] = 16'h0000;
      fr_i[3][n] = 16'h0000;
    end
    tmp = '{16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800, 16'h0900, 16'h0400, 16'h0500};
    for (int n = 0; n < 8; n++) fr_r[1][n] = tmp[n];
    tmp = '{16'h0100, 16'h0000, 16'h0500, 16'h0800, 16'h0600, 16'h0700, 16'h0300, 16'h0100};
    for (int n = 0; n < 8; n++) fr_r[3][n] = tmp[n];
    tmp = '{16'h0123, 16'h8456, 16'h0789, 16'h8ABC, 16'h0DEF, 16'h8012, 16'h0345, 16'h8678};
    for (int n = 0; n < 8; n++) fr_r[5][n] = tmp[n];
    tmp = '{16'h8111, 16'h0222, 16'h8333, 16'h0444, 16'h8555, 16'h0666, 16'h8777, 16'h0888};
    for (int n = 0; n < 8; n++) fr_i[5][n] = tmp[n];
    for (int id = 0; id < 8; id++) model_fft(id);

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    RST_N  = 1'b0;
    chk_en = 1'b1;

    // Ramp frame and its hand-computed bins.
    step(1'b1, 1'b1, 0);
    step(1'b0, 1'b1, -1);
    step(1'b0, 1'b1, -1);
    step(1'b0, 1'b1, -1);
    check("ramp_ready", 16'(ready), 16'h0001);
    check("ramp_out0_r", out_r[0], 16'h1C00);
    check("ramp_out0_i", out_i[0], 16'h0000);
    check("ramp_out2_r", out_r[2], 16'h8400);
    check("ramp_out2_i", out_i[2], 16'h0400);
    check("ramp_out4_r", out_r[4], 16'h8400);
    check("ramp_out4_i", out_i[4], 16'h0000);
    check("ramp_out6_r", out_r[6], 16'h8400);
    check("ramp_out6_i", out_i[6], 16'h8400);
    check_near("ramp_out1_i", out_i[1], 16'h09A8, 2);
    check_near("ramp_out7_i", out_i[7], 16'h89A8, 2);
    check("model_ramp1_i", ex_i[0][1], 16'h09A8);

    // Asynchronous reset mid-stream, checked before any clock edge.
    RST_N = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #2;
    RST_N = 1'b0;

    // Back-to-back streaming.
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 2);
    step(1'b1, 1'b1, 3);
    step(1'b0, 1'b1, -1);
    check("stream_a_out0_r", out_r[0], 16'h3000);
    check("stream_a_ready", 16'(ready), 16'h0001);
    step(1'b0, 1'b1, -1);
    check("stream_b_out0_r", out_r[0], 16'h2400);
    check("stream_b_ready", 16'(ready), 16'h0001);
    step(1'b0, 1'b1, -1);
    check("stream_c_out0_r", out_r[0], 16'h1F00);
    check("stream_c_ready", 16'(ready), 16'h0001);
    step(1'b0, 1'b1, -1);
    check("stream_drain_ready", 16'(ready), 16'h0000);

    // Stall with frames in flight.
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 2);
    step(1'b1, 1'b1, 3);
    step(1'b0, 1'b1, -1);
    step(1'b0, 1'b0, -1);
    check("stall1_out0_r", out_r[0], 16'h3000);
    check("stall1_ready", 16'(ready), 16'h0001);
    step(1'b0, 1'b0, -1);
    check("stall2_out0_r", out_r[0], 16'h3000);
    check("stall2_ready", 16'(ready), 16'h0001);
    step(1'b0, 1'b1, -1);
    check("stall_b_out0_r", out_r[0], 16'h2400);
    step(1'b0, 1'b1, -1);
    check("stall_c_out0_r", out_r[0], 16'h1F00);
    step(1'b0, 1'b1, -1);
    check("stall_drain_ready", 16'(ready), 16'h0000);

    // Frame written while stalled and then dropped; then overwritten before start.
    step(1'b1, 1'b0, 4);
    step(1'b0, 1'b0, -1);
    repeat (3) step(1'b0, 1'b1, -1);
    check("dropped_ready", 16'(ready), 16'h0000);
    step(1'b1, 1'b0, 4);
    step(1'b1, 1'b0, 5);
    repeat (3) step(1'b0, 1'b1, -1);
    check("overwrite_ready", 16'(ready), 16'h0001);

    // Mixed-sign complex frames back to back (model-checked).
    step(1'b1, 1'b1, 4);
    step(1'b1, 1'b1, 5);
    repeat (4) step(1'b0, 1'b1, -1);

    // Overflow.
`ifdef DIT_FFT_8_SATURATE_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'h7800;
`endif
    step(1'b1, 1'b1, 6);
    repeat (3) step(1'b0, 1'b1, -1);
    check("ovf_out0_r", out_r[0], ovf_exp);
    check("ovf_out0_i", out_i[0], 16'h0000);
    for (int k = 1; k < 8; k++) begin
      check($sformatf("ovf_out%0d_r", k), out_r[k], 16'h0000);
      check($sformatf("ovf_out%0d_i", k), out_i[k], 16'h0000);
    end

    // Negative zero everywhere.
    step(1'b1, 1'b1, 7);
    repeat (3) step(1'b0, 1'b1, -1);
    check("negzero_ready", 16'(ready), 16'h0001);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("negzero_out%0d_r", k), out_r[k], 16'h0000);
      check($sformatf("negzero_out%0d_i", k), out_i[k], 16'h0000);
    end

    repeat (2) step(1'b0, 1'b1, -1);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
